tilt_sensor_conditioner: RTL and testbench

TILT_SENSOR_CONDITIONER -- requirements
Module: tilt_sensor_conditioner

---
 rtl/tilt_sensor_conditioner.sv | 152 +++++++++++++++
 tb/tb_tilt_sensor_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tilt_sensor_conditioner.sv
// ============================================================================
// Module   : tilt_sensor_conditioner
// Brief    : Synchronises, debounces and hold-qualifies a tilt switch.
//            Optional macro TILT_EVENT_COUNT_EN enables the face-down event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tilt_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned HOLD_CYCLES       = 50000000,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  output logic       ledsign,
  output logic       tilt_stable,
  output logic       tilt_pulse,
  output logic [7:0] tilt_count
);

  localparam int unsigned c_deb_w  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned c_hold_w = $clog2(HOLD_CYCLES) + 1;
  localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    UP     = 2'd0,
    ARMING = 2'd1,
    DOWN   = 2'd2
  } state_t;

  logic               sensor_pol;
  logic               sync1_q;
  logic               sync_q;
  logic [c_deb_w-1:0] deb_cnt_q;
  logic [c_deb_w-1:0] deb_cnt_d;
  logic               stable_q;
  logic               stable_d;
  logic               pulse_q;
  logic               mismatch;
  logic               deb_done;

  state_t              state_q;
  logic [c_hold_w-1:0] hold_cnt_q;
  logic                ledsign_q;
  logic                arm_done;

  assign sensor_pol = sensor_raw ^ SENSOR_ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_pol;
      sync_q  <= sync1_q;
    end
  end

  // Counter holds the number of consecutive mismatches already seen; the
  // DEBOUNCE_CYCLES-th mismatch toggles the level instead of incrementing.
  assign mismatch = sync_q ^ stable_q;
  assign deb_done = mismatch && (deb_cnt_q == c_deb_last);

  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable_q;
    if (deb_done) begin
      stable_d = ~stable_q;
    end else if (mismatch) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      stable_q  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      stable_q  <= stable_d;
      pulse_q   <= deb_done;
    end
  end

  assign arm_done = (state_q == ARMING) && stable_q && (hold_cnt_q == c_hold_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UP;
      hold_cnt_q <= '0;
      ledsign_q  <= 1'b0;
    end else begin
      case (state_q)
        UP: begin
          hold_cnt_q <= '0;
          if (stable_q) begin
            state_q <= ARMING;
          end
        end
        ARMING: begin
          if (!stable_q) begin
            state_q    <= UP;
            hold_cnt_q <= '0;
          end else if (arm_done) begin
            state_q   <= DOWN;
            ledsign_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        DOWN: begin
          if (!stable_q) begin
            state_q   <= UP;
            ledsign_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= UP;
          hold_cnt_q <= '0;
          ledsign_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TILT_EVENT_COUNT_EN
  logic [7:0] evt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt_q <= 8'd0;
    end else if (arm_done && (evt_cnt_q != 8'hFF)) begin
      evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  assign tilt_count = evt_cnt_q;
`else
  assign tilt_count = 8'd0;
`endif

  assign tilt_stable = stable_q;
  assign tilt_pulse  = pulse_q;
  assign ledsign     = ledsign_q;

endmodule

`default_nettype wire

// File: tb/tb_tilt_sensor_conditioner.sv
// ============================================================================
// Module   : tb_tilt_sensor_conditioner
// Brief    : Directed scoreboard bench, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tilt_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_raw;
  logic       ledsign;
  logic       tilt_stable;
  logic       tilt_pulse;
  logic [7:0] tilt_count;

  typedef struct {
    string      tag;
    logic [10:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  tilt_sensor_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .HOLD_CYCLES      (8),
    .SENSOR_ACTIVE_LOW(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .ledsign    (ledsign),
    .tilt_stable(tilt_stable),
    .tilt_pulse (tilt_pulse),
    .tilt_count (tilt_count)
  );

  always #5 clk = ~clk;

  task automatic bump_count();
`ifdef TILT_EVENT_COUNT_EN
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic expect_edge(input string tag, input bit l, input bit s, input bit p);
    exp_t e;
    exp_t got;
    logic [10:0] obs;
    e.tag = tag;
    e.exp = {l, s, p, exp_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    obs = {ledsign, tilt_stable, tilt_pulse, tilt_count};
    n_cmp++;
    assert (obs === got.exp) else begin
      n_bad++;
      $error("FAIL %s observed={led,stab,pulse,cnt}=%b expected=%b", got.tag, obs, got.exp);
    end
  endtask

  // Full face-down qualification from rest: stable at edge 6, ledsign at edge 15.
  task automatic rise_full(input string tag);
    sensor_raw = 1'b1;
    for (int e = 1; e <= 5; e++) expect_edge($sformatf("%s_rise_e%0d", tag, e), 0, 0, 0);
    expect_edge($sformatf("%s_rise_e6", tag), 0, 1, 1);
    for (int e = 7; e <= 14; e++) expect_edge($sformatf("%s_arm_e%0d", tag, e), 0, 1, 0);
    bump_count();
    expect_edge($sformatf("%s_down_e15", tag), 1, 1, 0);
  endtask

  task automatic fall_full(input string tag);
    sensor_raw = 1'b0;
    for (int e = 1; e <= 5; e++) expect_edge($sformatf("%s_fall_e%0d", tag, e), 1, 1, 0);
    expect_edge($sformatf("%s_fall_e6", tag), 1, 0, 1);
    expect_edge($sformatf("%s_up_e7", tag), 0, 0, 0);
  endtask

  initial begin
    rst        = 1'b1;
    sensor_raw = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) expect_edge($sformatf("reset_%0d", i), 0, 0, 0);

    rst        = 1'b0;
    sensor_raw = 1'b0;
    for (int i = 0; i < 3; i++) expect_edge($sformatf("idle_%0d", i), 0, 0, 0);

    sensor_raw = 1'b1;
    for (int i = 0; i < 3; i++) expect_edge($sformatf("glitch_hi_%0d", i), 0, 0, 0);
    sensor_raw = 1'b0;
    for (int i = 0; i < 8; i++) expect_edge($sformatf("glitch_lo_%0d", i), 0, 0, 0);

    rise_full("main");
    for (int i = 0; i < 3; i++) expect_edge($sformatf("hold_down_%0d", i), 1, 1, 0);
    fall_full("main");

    // Release so the FSM sees tilt_stable=0 with the hold counter at 5.
    sensor_raw = 1'b1;
    for (int e = 1; e <= 5; e++) expect_edge($sformatf("rel_rise_e%0d", e), 0, 0, 0);
    expect_edge("rel_rise_e6", 0, 1, 1);
    sensor_raw = 1'b0;
    for (int e = 7; e <= 11; e++) expect_edge($sformatf("rel_arm_e%0d", e), 0, 1, 0);
    expect_edge("rel_fall_e12", 0, 0, 1);
    for (int e = 13; e <= 20; e++) expect_edge($sformatf("rel_up_e%0d", e), 0, 0, 0);
    rise_full("after_rel");
    fall_full("after_rel");

    sensor_raw = 1'b1;
    for (int i = 0; i < 4; i++) expect_edge($sformatf("rst_deb_pre_%0d", i), 0, 0, 0);
    rst = 1'b1;
    expect_edge("rst_deb_hit", 0, 0, 0);
    rst = 1'b0;
    rise_full("after_rst_deb");
    fall_full("after_rst_deb");

    sensor_raw = 1'b1;
    for (int e = 1; e <= 5; e++) expect_edge($sformatf("rst_arm_rise_e%0d", e), 0, 0, 0);
    expect_edge("rst_arm_rise_e6", 0, 1, 1);
    for (int e = 7; e <= 10; e++) expect_edge($sformatf("rst_arm_e%0d", e), 0, 1, 0);
    rst = 1'b1;
    expect_edge("rst_arm_hit", 0, 0, 0);
    rst        = 1'b0;
    sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) expect_edge($sformatf("rst_arm_post_%0d", i), 0, 0, 0);

    for (int q = 0; q < 257; q++) begin
      rise_full($sformatf("loop%0d", q));
      fall_full($sformatf("loop%0d", q));
    end
`ifdef TILT_EVENT_COUNT_EN
    n_cmp++;
    assert (tilt_count === 8'd255) else begin
      n_bad++;
      $error("FAIL count_saturated observed=%0d expected=255", tilt_count);
    end
`else
    n_cmp++;
    assert (tilt_count === 8'd0) else begin
      n_bad++;
      $error("FAIL count_disabled observed=%0d expected=0", tilt_count);
    end
`endif
    expect_edge("final_idle", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
